// File: rtl/player_anim_ctrl.sv
// Per-player sprite animation sequencer: turns held key intents into a sprite
// frame index and facing, advancing only on rising edges of the vsync strobe.
module player_anim_ctrl #(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_punch,
  input  logic       key_kick,
  output logic [9:0] action,
  output logic [9:0] direction,
  output logic       busy,
  output logic       hit_frame,
  output logic       walking
);

  localparam int HW = $clog2(FRAMES_PER_STEP) + 1;
  localparam logic [HW-1:0] LAST_HOLD = HW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, WALK, PUNCH, KICK} state_t;

  state_t        state, next_state;
  logic [9:0]    next_action, next_direction;
  logic [HW-1:0] hold_cnt, next_hold;
  logic          frame_clk_d;
  logic          tick, mv;

  assign tick = frame_clk & ~frame_clk_d;
  assign mv   = key_left ^ key_right;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      action      <= 10'd9;
      direction   <= 10'd1;
      hold_cnt    <= '0;
      frame_clk_d <= 1'b0;
      busy        <= 1'b0;
      hit_frame   <= 1'b0;
      walking     <= 1'b0;
    end else begin
      state       <= next_state;
      action      <= next_action;
      direction   <= next_direction;
      hold_cnt    <= next_hold;
      frame_clk_d <= frame_clk;
      busy        <= (next_state == PUNCH) || (next_state == KICK);
      hit_frame   <= (next_action == 10'd7) || (next_action == 10'd13);
      walking     <= (next_state == WALK);
    end
  end

  always_comb begin
    next_state     = state;
    next_action    = action;
    next_direction = direction;
    next_hold      = hold_cnt;
    if (tick) begin
      case (state)
        IDLE, WALK: begin
          if (mv) next_direction = key_right ? 10'd1 : 10'd0;
          if (key_kick) begin
            next_state  = KICK;
            next_action = 10'd11;
            next_hold   = '0;
          end else if (key_punch) begin
            next_state  = PUNCH;
            next_action = 10'd6;
            next_hold   = '0;
          end else if (mv) begin
            if (state == IDLE) begin
              next_state  = WALK;
              next_action = 10'd0;
              next_hold   = '0;
            end else if (hold_cnt == LAST_HOLD) begin
              next_hold   = '0;
              next_action = (action == 10'd5) ? 10'd0 : action + 10'd1;
            end else begin
              next_hold = hold_cnt + HW'(1);
            end
          end else begin
            next_state  = IDLE;
            next_action = 10'd9;
            next_hold   = '0;
          end
        end
        PUNCH, KICK: begin
          // Attacks run to completion; keys only matter on the exit tick.
          if (hold_cnt == LAST_HOLD) begin
            next_hold = '0;
            if (action == ((state == PUNCH) ? 10'd8 : 10'd14)) begin
              if (mv) begin
                next_state     = WALK;
                next_action    = 10'd0;
                next_direction = key_right ? 10'd1 : 10'd0;
              end else begin
                next_state  = IDLE;
                next_action = 10'd9;
              end
            end else begin
              next_action = action + 10'd1;
            end
          end else begin
            next_hold = hold_cnt + HW'(1);
          end
        end
        default: begin
          next_state  = IDLE;
          next_action = 10'd9;
          next_hold   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Scoreboarded bench for player_anim_ctrl: FPS=2 and FPS=1 builds share stimulus
// and are compared against a tick-counting animation model.
module tb_player_anim_ctrl;

  typedef struct packed {
    logic [9:0] action;
    logic [9:0] direction;
    logic       busy;
    logic       hit;
    logic       walking;
  } out_t;

  typedef struct packed {
    out_t fps2;
    out_t fps1;
  } exp_t;

  // mode: 0 idle, 1 walk, 2 punch, 3 kick; t counts ticks spent in the mode
  typedef struct {
    int mode;
    int t;
    int dir;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fc = 1'b0;
  logic kl = 1'b0, kr = 1'b0, kp = 1'b0, kk = 1'b0;

  out_t got2, got1;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];
  mdl_t m2, m1;
  bit   prev_fc;

  always #5 clk = ~clk;

  player_anim_ctrl #(.FRAMES_PER_STEP(2)) dut2 (
    .Clk(clk), .Reset(rst), .frame_clk(fc),
    .key_left(kl), .key_right(kr), .key_punch(kp), .key_kick(kk),
    .action(got2.action), .direction(got2.direction),
    .busy(got2.busy), .hit_frame(got2.hit), .walking(got2.walking)
  );

  player_anim_ctrl #(.FRAMES_PER_STEP(1)) dut1 (
    .Clk(clk), .Reset(rst), .frame_clk(fc),
    .key_left(kl), .key_right(kr), .key_punch(kp), .key_kick(kk),
    .action(got1.action), .direction(got1.direction),
    .busy(got1.busy), .hit_frame(got1.hit), .walking(got1.walking)
  );

  function automatic mdl_t model_reset();
    mdl_t s;
    s.mode = 0;
    s.t    = 0;
    s.dir  = 1;
    return s;
  endfunction

  function automatic mdl_t model_step(mdl_t s, int fps, bit l, bit r, bit p, bit k);
    mdl_t n = s;
    bit mv = l ^ r;
    if (s.mode >= 2) begin
      n.t = s.t + 1;
      if (n.t == ((s.mode == 2) ? 3 : 4) * fps) begin
        n.mode = mv ? 1 : 0;
        n.t    = 0;
        if (mv) n.dir = r ? 1 : 0;
      end
    end else begin
      if (mv) n.dir = r ? 1 : 0;
      if (k) begin
        n.mode = 3; n.t = 0;
      end else if (p) begin
        n.mode = 2; n.t = 0;
      end else if (mv) begin
        if (s.mode == 1) n.t = s.t + 1;
        else begin n.mode = 1; n.t = 0; end
      end else begin
        n.mode = 0; n.t = 0;
      end
    end
    return n;
  endfunction

  function automatic out_t model_out(mdl_t s, int fps);
    out_t o;
    int a;
    case (s.mode)
      1:       a = (s.t / fps) % 6;
      2:       a = 6 + s.t / fps;
      3:       a = 11 + s.t / fps;
      default: a = 9;
    endcase
    o.action    = 10'(a);
    o.direction = 10'(s.dir);
    o.busy      = (s.mode >= 2);
    o.hit       = (a == 7) || (a == 13);
    o.walking   = (s.mode == 1);
    return o;
  endfunction

  // One Clk cycle of stimulus; the expected post-edge outputs are queued.
  task automatic apply_stimulus(input bit r_in, input bit f, input bit l, input bit r,
                                input bit p, input bit k);
    exp_t e;
    @(negedge clk);
    rst = r_in; fc = f; kl = l; kr = r; kp = p; kk = k;
    if (r_in) begin
      m2 = model_reset();
      m1 = model_reset();
      prev_fc = 1'b0;
    end else begin
      if (f && !prev_fc) begin
        m2 = model_step(m2, 2, l, r, p, k);
        m1 = model_step(m1, 1, l, r, p, k);
      end
      prev_fc = f;
    end
    e.fps2 = model_out(m2, 2);
    e.fps1 = model_out(m1, 1);
    exp_q.push_back(e);
  endtask

  task automatic do_tick(input bit l, input bit r, input bit p, input bit k,
                         input int hi, input int lo);
    for (int i = 0; i < hi; i++) apply_stimulus(1'b0, 1'b1, l, r, p, k);
    for (int i = 0; i < lo; i++) apply_stimulus(1'b0, 1'b0, l, r, p, k);
  endtask

  task automatic check_output(input out_t got, input out_t exp, input string name);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got action=%0d dir=%0d busy=%0b hit=%0b walk=%0b required action=%0d dir=%0d busy=%0b hit=%0b walk=%0b",
               name, $time, got.action, got.direction, got.busy, got.hit, got.walking,
               exp.action, exp.direction, exp.busy, exp.hit, exp.walking);
    end
  endtask

  // Monitor: compares every cycle that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(got2, e.fps2, "fps2");
        check_output(got1, e.fps1, "fps1");
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit r_l, r_r, r_p, r_k, r_f;
    m2 = model_reset();
    m1 = model_reset();
    prev_fc = 1'b0;

    // Reset held while keys and strobe toggle
    for (int i = 0; i < 3; i++) begin
      bit [3:0] pat = 4'(i * 5 + 3);
      apply_stimulus(1'b1, pat[0], pat[1], pat[2], pat[3], pat[0]);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Walk right, strobe held high several cycles per tick
    for (int i = 0; i < 14; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);

    // Walk left, punch for one tick, keep walking left
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
    do_tick(1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
    for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1, 1);

    // Idle, then kick+punch together; right pressed mid-kick
    for (int i = 0; i < 2; i++) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    do_tick(1'b0, 1'b0, 1'b1, 1'b1, 1, 1);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    for (int i = 0; i < 8; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0, 1, 1);

    // Both directions held
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1, 1);

    // Left walk, kick, reset during action 12
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
    do_tick(1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized play
    r_l = 0; r_r = 0; r_p = 0; r_k = 0; r_f = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) r_l = ~r_l;
      if ($urandom_range(0, 7) == 0) r_r = ~r_r;
      r_p = ($urandom_range(0, 15) == 0);
      r_k = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) r_f = ~r_f;
      apply_stimulus($urandom_range(0, 299) == 0, r_f, r_l, r_r, r_p, r_k);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
